// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: legacy single-pass ops plus iterative multiply/divide,
// operands in and result out over valid/ready handshakes.
module alu_seq #(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int unsigned      CNTW     = $clog2(WIDTH) + 1;
    localparam int unsigned      ACCW     = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    localparam logic [4:0] OP_OR    = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_XOR   = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SRL   = 5'b00101;
    localparam logic [4:0] OP_SUB   = 5'b00110;
    localparam logic [4:0] OP_SLTU  = 5'b00111;
    localparam logic [4:0] OP_SRA   = 5'b01000;
    localparam logic [4:0] OP_NOR   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01110;
    localparam logic [4:0] OP_PASSB = 5'b01111;
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULHU = 5'b10001;
    localparam logic [4:0] OP_DIVU  = 5'b10010;
    localparam logic [4:0] OP_REMU  = 5'b10011;
    localparam logic [4:0] OP_DIV   = 5'b10100;
    localparam logic [4:0] OP_REM   = 5'b10101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic [ACCW-1:0]   acc;
    logic [WIDTH-1:0]  opnd;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              neg_r;

    // Accept-time decode: single-pass result, special cases, iteration setup
    logic                    start_iter;
    logic [WIDTH-1:0]        fast_res;
    logic [SHW-1:0]          shamt;
    logic signed [WIDTH-1:0] a_signed;
    logic                    sgn_op;
    logic                    a_neg;
    logic                    b_neg;
    logic [WIDTH-1:0]        a_mag;
    logic [WIDTH-1:0]        b_mag;
    logic                    div_by_zero;
    logic                    div_ovf;
    logic [ACCW-1:0]         acc_init;
    logic [WIDTH-1:0]        opnd_init;

    always_comb begin
        shamt       = B[SHW-1:0];
        a_signed    = A;
        sgn_op      = alu_op[2];
        a_neg       = sgn_op & A[WIDTH-1];
        b_neg       = sgn_op & B[WIDTH-1];
        a_mag       = a_neg ? -A : A;
        b_mag       = b_neg ? -B : B;
        div_by_zero = (B == '0);
        div_ovf     = sgn_op && (A == MOST_NEG) && (B == ALL_ONES);
        start_iter  = 1'b0;
        fast_res    = '0;
        case (alu_op)
            OP_OR:    fast_res = A | B;
            OP_ADD:   fast_res = A + B;
            OP_XOR:   fast_res = A ^ B;
            OP_SLL:   fast_res = A << shamt;
            OP_SRL:   fast_res = A >> shamt;
            OP_SUB:   fast_res = A - B;
            OP_SLTU:  fast_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SRA:   fast_res = a_signed >>> shamt;
            OP_NOR:   fast_res = ~(A | B);
            OP_AND:   fast_res = A & B;
            OP_PASSB: fast_res = B;
            OP_MUL, OP_MULHU: start_iter = 1'b1;
            OP_DIVU, OP_DIV: begin
                if (div_by_zero)  fast_res = ALL_ONES;
                else if (div_ovf) fast_res = MOST_NEG;
                else              start_iter = 1'b1;
            end
            OP_REMU, OP_REM: begin
                if (div_by_zero)  fast_res = A;
                else if (div_ovf) fast_res = '0;
                else              start_iter = 1'b1;
            end
            default:  fast_res = '0;
        endcase
        // Multiply keeps the multiplier in the low half; divide keeps the dividend magnitude there
        if (alu_op[2:1] == 2'b00) begin
            acc_init  = {{WIDTH{1'b0}}, B};
            opnd_init = A;
        end else begin
            acc_init  = {{WIDTH{1'b0}}, a_mag};
            opnd_init = b_mag;
        end
    end

    // One shift-add or restoring-divide step per cycle on the shared accumulator
    logic             is_mul;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [ACCW-1:0]  acc_nxt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] iter_res;

    always_comb begin
        is_mul    = (op_q[2:1] == 2'b00);
        mul_sum   = {1'b0, acc[ACCW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[ACCW-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = ~div_diff[WIDTH];
        if (is_mul) begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            acc_nxt = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                       acc[WIDTH-2:0], div_ge};
        end
        quo = acc_nxt[WIDTH-1:0];
        rem = acc_nxt[ACCW-1:WIDTH];
        case (op_q)
            3'd0:       iter_res = acc_nxt[WIDTH-1:0];
            3'd1:       iter_res = acc_nxt[ACCW-1:WIDTH];
            3'd2, 3'd4: iter_res = neg_q ? -quo : quo;
            default:    iter_res = neg_r ? -rem : rem;
        endcase
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        op_q     <= alu_op[2:0];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        if (start_iter) begin
                            acc   <= acc_init;
                            opnd  <= opnd_init;
                            cnt   <= CNTW'(WIDTH);
                            state <= BUSY;
                        end else begin
                            result    <= fast_res;
                            zero      <= (fast_res == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt - CNTW'(1);
                    if (cnt == CNTW'(1)) begin
                        result    <= iter_res;
                        zero      <= (iter_res == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
